// File: rtl/program_counter_stack_if.sv
// program_counter_stack_if: command strobes, target/offset, fetch address and stack status
interface program_counter_stack_if #(
   parameter int WIDTH = 8
);
   logic             pc_enable;
   logic             ld;
   logic             br;
   logic             call;
   logic             ret;
   logic [WIDTH-1:0] inp;
   logic [WIDTH-1:0] out;
   logic             stack_empty;
   logic             stack_full;
   logic             stack_err;
   modport master (
      output pc_enable, ld, br, call, ret, inp,
      input  out, stack_empty, stack_full, stack_err
   );
   modport slave (
      input  pc_enable, ld, br, call, ret, inp,
      output out, stack_empty, stack_full, stack_err
   );
endinterface

// File: rtl/program_counter_stack.sv
// program_counter_stack: fetch-address register with return-address stack, relative branch and sticky stack error
module program_counter_stack #(
   parameter int               WIDTH        = 8,
   parameter int               STACK_DEPTH  = 4,
   parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
   parameter int               INC          = 1
) (
   input logic                    clk,
   input logic                    reset,
   program_counter_stack_if.slave bus
);
   localparam int            PW   = $clog2(STACK_DEPTH + 1);
   localparam logic [PW-1:0] FULL = PW'(STACK_DEPTH);
   logic [WIDTH-1:0] pc_q, pc_d, pc_inc, top;
   logic [PW-1:0]    sp_q, sp_d;
   logic             push, err_q, err_d, empty_q, full_q;
   logic [WIDTH-1:0] stack_q [STACK_DEPTH];
   assign pc_inc = pc_q + WIDTH'(INC);
   // top of stack is the entry just below the pointer
   always_comb begin
      top = '0;
      for (int i = 0; i < STACK_DEPTH; i++)
         if (sp_q == PW'(i + 1)) top = stack_q[i];
   end
   // ret > call > ld > br > pc_enable > hold
   always_comb begin
      pc_d  = pc_q;
      sp_d  = sp_q;
      err_d = err_q;
      push  = 1'b0;
      if (bus.ret) begin
         if (sp_q == '0) err_d = 1'b1;
         else begin
            pc_d = top;
            sp_d = sp_q - PW'(1);
         end
      end else if (bus.call) begin
         if (sp_q == FULL) err_d = 1'b1;
         else begin
            push = 1'b1;
            pc_d = bus.inp;
            sp_d = sp_q + PW'(1);
         end
      end else if (bus.ld) pc_d = bus.inp;
      else if (bus.br) pc_d = pc_q + bus.inp;
      else if (bus.pc_enable) pc_d = pc_inc;
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q    <= RESET_VECTOR;
         sp_q    <= '0;
         err_q   <= 1'b0;
         empty_q <= 1'b1;
         full_q  <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         sp_q    <= sp_d;
         err_q   <= err_d;
         empty_q <= sp_d == '0;
         full_q  <= sp_d == FULL;
      end
   end
   // storage has no reset; the pointer alone defines validity
   always_ff @(posedge clk) begin
      for (int i = 0; i < STACK_DEPTH; i++)
         if (reset && push && sp_q == PW'(i)) stack_q[i] <= pc_inc;
   end
   assign bus.out         = pc_q;
   assign bus.stack_empty = empty_q;
   assign bus.stack_full  = full_q;
   assign bus.stack_err   = err_q;
endmodule
